// File: rtl/rtype_rf_sequencer_if.sv
// rtype_rf_sequencer_if: instruction, register-file and ALU signals of the R-type sequencer.
// Rev 1.0
`default_nettype none

interface rtype_rf_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FUNC_W = 11
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_dout_1;
  logic [DATA_W-1:0] rf_dout_2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_din;
  logic              alu_req;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [FUNC_W-1:0] alu_func;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              wb_done;
  logic              illegal;

  modport master (
    input  instr_valid, instr, rf_dout_1, rf_dout_2, alu_done, alu_result,
    output instr_ready, rf_rs1, rf_rs2, rf_we, rf_rd, rf_din,
           alu_req, alu_a, alu_b, alu_func, wb_done, illegal
  );

  modport slave (
    output instr_valid, instr, rf_dout_1, rf_dout_2, alu_done, alu_result,
    input  instr_ready, rf_rs1, rf_rs2, rf_we, rf_rd, rf_din,
           alu_req, alu_a, alu_b, alu_func, wb_done, illegal
  );
endinterface

`default_nettype wire

// File: rtl/rtype_rf_sequencer.sv
// rtype_rf_sequencer: reads two operands, hands them to the ALU, writes the result back.
// Rev 1.0
`default_nettype none

module rtype_rf_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int FUNC_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  rtype_rf_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  // Opcode is only inspected at accept time, so just the operand fields are kept.
  logic [25:0]       instr_q, instr_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              instr_ready_q, instr_ready_d;
  logic              alu_req_q, alu_req_d;
  logic              rf_we_q, rf_we_d;
  logic              wb_done_q, wb_done_d;
  logic              illegal_q, illegal_d;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    result_d      = result_q;
    instr_ready_d = instr_ready_q;
    alu_req_d     = alu_req_q;
    rf_we_d       = 1'b0;
    wb_done_d     = 1'b0;
    illegal_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid && instr_ready_q) begin
          instr_d = bus.instr[25:0];
          if (bus.instr[31:26] == 6'h00) begin
            state_d       = S_READ;
            instr_ready_d = 1'b0;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_READ: begin
        alu_a_d   = bus.rf_dout_1;
        alu_b_d   = bus.rf_dout_2;
        alu_req_d = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        if (bus.alu_done) begin
          result_d  = bus.alu_result;
          alu_req_d = 1'b0;
          // Writes to R0 are dropped but the instruction still retires.
          rf_we_d   = (instr_q[15:11] != 5'd0);
          wb_done_d = 1'b1;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        instr_ready_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: begin
        instr_ready_d = 1'b1;
        alu_req_d     = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      result_q      <= '0;
      instr_ready_q <= 1'b1;
      alu_req_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      wb_done_q     <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      result_q      <= result_d;
      instr_ready_q <= instr_ready_d;
      alu_req_q     <= alu_req_d;
      rf_we_q       <= rf_we_d;
      wb_done_q     <= wb_done_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.rf_rs1      = instr_q[25:21];
  assign bus.rf_rs2      = instr_q[20:16];
  assign bus.rf_rd       = instr_q[15:11];
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_din      = result_q;
  assign bus.alu_req     = alu_req_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_func    = instr_q[FUNC_W-1:0];
  assign bus.wb_done     = wb_done_q;
  assign bus.illegal     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_rtype_rf_sequencer.sv
// tb_rtype_rf_sequencer: directed bench with a register-file model and a fixed-latency ALU responder.
// Rev 1.0
`default_nettype none

module tb_rtype_rf_sequencer;
  localparam int ALU_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtype_rf_sequencer_if #(.DATA_W(32), .ADDR_W(5), .FUNC_W(11)) ifc ();

  rtype_rf_sequencer #(.DATA_W(32), .ADDR_W(5), .FUNC_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Register file model: writes whatever rf_we requests, so a stray R0 write is visible.
  logic [31:0] rf [32];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          we_cnt = 0;

  assign ifc.rf_dout_1 = rf[ifc.rf_rs1];
  assign ifc.rf_dout_2 = rf[ifc.rf_rs2];

  always @(posedge clk) begin
    if (ifc.rf_we) rf[ifc.rf_rd] <= ifc.rf_din;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  always @(negedge clk) if (ifc.rf_we) we_cnt <= we_cnt + 1;

  // ALU responder: alu_done in the ALU_LAT-th EXEC cycle, or forced by the bench.
  logic        alu_en = 1'b1;
  logic        force_done = 1'b0;
  logic [31:0] force_res = '0;
  int          alu_cnt = 0;

  always @(negedge clk) begin
    if (!alu_en) begin
      ifc.alu_done   = force_done;
      ifc.alu_result = force_res;
      alu_cnt        = 0;
    end else if (ifc.alu_req && !ifc.alu_done) begin
      if (alu_cnt == ALU_LAT - 1) begin
        ifc.alu_done   = 1'b1;
        ifc.alu_result = ifc.alu_a + ifc.alu_b;
        alu_cnt        = 0;
      end else begin
        alu_cnt = alu_cnt + 1;
      end
    end else begin
      ifc.alu_done = 1'b0;
      alu_cnt      = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Offer one instruction for exactly one cycle; caller ensures instr_ready is high.
  task automatic issue(input logic [31:0] ins);
    ifc.instr       = ins;
    ifc.instr_valid = 1'b1;
    tick();
    ifc.instr_valid = 1'b0;
  endtask

  int          before_we;
  int          accepts, wbs, wb1_cyc, acc2_cyc;
  logic        acc_pend;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    ifc.instr_valid = 1'b0;
    ifc.instr       = '0;
    ifc.alu_done    = 1'b0;
    ifc.alu_result  = '0;
    tick();
    preload(5'd1, 32'd1);
    preload(5'd2, 32'd2);

    // Reset state
    check("rst_ready",   ifc.instr_ready, 1);
    check("rst_alu_req", ifc.alu_req, 0);
    check("rst_we",      ifc.rf_we, 0);
    check("rst_wb_done", ifc.wb_done, 0);
    check("rst_illegal", ifc.illegal, 0);
    check("rst_alu_a",   ifc.alu_a, 0);
    rst = 1'b0;
    tick();

    // Basic add r3 = r1 + r2, ALU latency 2
    issue({6'h00, 5'd1, 5'd2, 5'd3, 11'h020});
    check("t1_read_rs1",   ifc.rf_rs1, 1);
    check("t1_read_rs2",   ifc.rf_rs2, 2);
    check("t1_read_ready", ifc.instr_ready, 0);
    tick();
    check("t1_exec_req",  ifc.alu_req, 1);
    check("t1_exec_a",    ifc.alu_a, 1);
    check("t1_exec_b",    ifc.alu_b, 2);
    check("t1_exec_func", ifc.alu_func, 32'h020);
    tick();
    check("t1_exec2_we", ifc.rf_we, 0);
    tick();
    check("t1_wb_we",   ifc.rf_we, 1);
    check("t1_wb_rd",   ifc.rf_rd, 3);
    check("t1_wb_din",  ifc.rf_din, 3);
    check("t1_wb_done", ifc.wb_done, 1);
    check("t1_wb_req",  ifc.alu_req, 0);
    tick();
    check("t1_idle_ready", ifc.instr_ready, 1);
    check("t1_idle_we",    ifc.rf_we, 0);
    check("t1_idle_wb",    ifc.wb_done, 0);
    check("t1_rf3",        rf[3], 3);

    // rd = 0: retires without writing
    before_we = we_cnt;
    issue({6'h00, 5'd1, 5'd2, 5'd0, 11'h020});
    repeat (3) tick();
    check("t2_wb_done", ifc.wb_done, 1);
    check("t2_wb_we",   ifc.rf_we, 0);
    tick();
    check("t2_rf0",    rf[0], 0);
    check("t2_we_cnt", we_cnt, before_we);

    // Illegal opcode
    issue({6'h08, 5'd1, 5'd2, 5'd3, 11'h020});
    check("t3_illegal", ifc.illegal, 1);
    check("t3_ready",   ifc.instr_ready, 1);
    check("t3_req",     ifc.alu_req, 0);
    tick();
    check("t3_illegal_clr", ifc.illegal, 0);
    check("t3_req2",        ifc.alu_req, 0);
    check("t3_we",          ifc.rf_we, 0);
    check("t3_ready2",      ifc.instr_ready, 1);

    // Dependency: r3 = 5 + 2 = 7, then r4 = r3 + r3 offered during WB
    preload(5'd1, 32'd5);
    issue({6'h00, 5'd1, 5'd2, 5'd3, 11'h020});
    repeat (3) tick();
    check("t4_wb1_din", ifc.rf_din, 7);
    ifc.instr       = {6'h00, 5'd3, 5'd3, 5'd4, 11'h022};
    ifc.instr_valid = 1'b1;
    tick();
    check("t4_ready_after_wb", ifc.instr_ready, 1);
    tick();
    ifc.instr_valid = 1'b0;
    check("t4_read_rs1", ifc.rf_rs1, 3);
    tick();
    check("t4_exec_a",    ifc.alu_a, 7);
    check("t4_exec_b",    ifc.alu_b, 7);
    check("t4_exec_func", ifc.alu_func, 32'h022);
    repeat (2) tick();
    check("t4_wb_rd",  ifc.rf_rd, 4);
    check("t4_wb_din", ifc.rf_din, 14);
    tick();

    // Reset in EXEC, alu_done arriving after release
    alu_en     = 1'b0;
    before_we  = we_cnt;
    issue({6'h00, 5'd1, 5'd2, 5'd7, 11'h020});
    tick();
    check("t5_exec_req", ifc.alu_req, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_req",   ifc.alu_req, 0);
    check("t5_rst_ready", ifc.instr_ready, 1);
    check("t5_rst_a",     ifc.alu_a, 0);
    check("t5_rst_rs1",   ifc.rf_rs1, 0);
    tick();
    rst        = 1'b0;
    force_res  = 32'd99;
    force_done = 1'b1;
    repeat (2) tick();
    force_done = 1'b0;
    tick();
    check("t5_post_we",    ifc.rf_we, 0);
    check("t5_post_wb",    ifc.wb_done, 0);
    check("t5_post_req",   ifc.alu_req, 0);
    check("t5_post_ready", ifc.instr_ready, 1);
    tick();
    check("t5_rf7",    rf[7], 0);
    check("t5_we_cnt", we_cnt, before_we);
    alu_en = 1'b1;
    tick();

    // valid held through busy states: r6 = 2+2, then r5 = 5+5
    accepts  = 0;
    wbs      = 0;
    wb1_cyc  = -1;
    acc2_cyc = -1;
    acc_pend = 1'b0;
    ifc.instr       = {6'h00, 5'd2, 5'd2, 5'd6, 11'h020};
    ifc.instr_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (acc_pend) begin
        acc_pend = 1'b0;
        if (accepts == 1) ifc.instr = {6'h00, 5'd1, 5'd1, 5'd5, 11'h020};
        else ifc.instr_valid = 1'b0;
      end
      if (ifc.wb_done) begin
        wbs++;
        if (wbs == 1) wb1_cyc = c;
      end
      if (ifc.instr_valid && ifc.instr_ready) begin
        accepts++;
        if (accepts == 2) acc2_cyc = c;
        acc_pend = 1'b1;
      end
      tick();
    end
    ifc.instr_valid = 1'b0;
    check("t6_accepts",   accepts, 2);
    check("t6_retires",   wbs, 2);
    check("t6_acc2_cyc",  acc2_cyc, wb1_cyc + 1);
    check("t6_wb1_cyc",   wb1_cyc, 4);
    check("t6_rf6",       rf[6], 4);
    check("t6_rf5",       rf[5], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
